// File: rtl/usb_frame_packer.sv
// Packs ADC samples into fixed-length framed 16-bit words for the USB data FIFO.
// Optional checksum word before the trailer is enabled by defining USB_FRAME_CHECKSUM_EN.
module usb_frame_packer #(
  parameter int unsigned SAMPLES_PER_FRAME = 254,
  parameter logic [15:0] HEADER_WORD       = 16'hEB90,
  parameter logic [15:0] TRAILER_WORD      = 16'h5A5A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_acq_enable,
  input  logic [1:0]  in_chn_select,
  input  logic        in_adc_valid,
  input  logic [15:0] in_adc_data,
  input  logic        in_fifo_full,
  output logic        out_fifo_wr_en,
  output logic [15:0] out_fifo_din,
  input  logic        in_clr_status,
  output logic        out_busy,
  output logic [15:0] out_frame_count,
  output logic        out_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_INFO, S_DATA, S_PAD, S_CSUM, S_TAIL
  } state_t;

  localparam logic [9:0] LAST_SLOT = 10'(SAMPLES_PER_FRAME - 1);

  state_t      state;
  logic [9:0]  slot;
  logic        hold_full;
  logic [15:0] hold_data;
  logic [1:0]  chn;
  logic        word_present;
  logic [15:0] word;
  logic        wr;
  logic        drain;
  logic        accept;
  logic        take;
  logic        drop;
  logic        frame_start;
`ifdef USB_FRAME_CHECKSUM_EN
  logic [15:0] csum;
`endif

  // Word offered to the FIFO in the current state
  always_comb begin
    word_present = 1'b0;
    word         = 16'h0000;
    case (state)
      S_HEAD: begin
        word_present = 1'b1;
        word         = HEADER_WORD;
      end
      S_INFO: begin
        word_present = 1'b1;
        word         = {out_frame_count[7:0], 6'b000000, chn};
      end
      S_DATA: begin
        word_present = hold_full;
        word         = hold_full ? hold_data : 16'h0000;
      end
      S_PAD: begin
        word_present = 1'b1;
      end
      S_CSUM: begin
        word_present = 1'b1;
`ifdef USB_FRAME_CHECKSUM_EN
        word         = csum;
`endif
      end
      S_TAIL: begin
        word_present = 1'b1;
        word         = TRAILER_WORD;
      end
      default: begin
        word_present = 1'b0;
        word         = 16'h0000;
      end
    endcase
  end

  assign wr             = word_present & ~in_fifo_full;
  assign out_fifo_wr_en = wr;
  assign out_fifo_din   = word;
  assign out_busy       = (state != S_IDLE);

  // A held sample may be replaced in the same cycle it is written out
  assign drain       = (state == S_DATA) & wr;
  assign accept      = in_adc_valid & in_acq_enable;
  assign take        = accept & (~hold_full | drain);
  assign drop        = accept & hold_full & ~drain;
  assign frame_start = (state == S_IDLE) & in_acq_enable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      slot            <= 10'd0;
      hold_full       <= 1'b0;
      out_frame_count <= 16'h0000;
      out_overflow    <= 1'b0;
    end else begin
      if (take)
        hold_full <= 1'b1;
      else if (drain)
        hold_full <= 1'b0;

      if (drop)
        out_overflow <= 1'b1;
      else if (in_clr_status)
        out_overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          slot <= 10'd0;
          if (in_acq_enable)
            state <= S_HEAD;
        end
        S_HEAD: if (wr) state <= S_INFO;
        S_INFO: begin
          if (wr) begin
            state <= S_DATA;
            slot  <= 10'd0;
          end
        end
        S_DATA, S_PAD: begin
          if (wr) begin
            if (slot == LAST_SLOT) begin
`ifdef USB_FRAME_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_TAIL;
`endif
            end else begin
              slot <= slot + 10'd1;
            end
          end else if (state == S_DATA && !hold_full && !in_acq_enable) begin
            state <= S_PAD;
          end
        end
        S_CSUM: if (wr) state <= S_TAIL;
        S_TAIL: begin
          if (wr) begin
            state           <= S_IDLE;
            out_frame_count <= out_frame_count + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: meaningful only once qualified by the control state
  always_ff @(posedge clk) begin
    if (take)
      hold_data <= in_adc_data;
    if (frame_start)
      chn <= in_chn_select;
`ifdef USB_FRAME_CHECKSUM_EN
    if (frame_start)
      csum <= 16'h0000;
    else if (drain)
      csum <= csum + hold_data;
`endif
  end

endmodule

// File: tb/tb_usb_frame_packer.sv
// Bench for usb_frame_packer: directed scenarios plus randomized frames checked against a frame-level model.
module tb_usb_frame_packer;

  localparam int unsigned SPF = 4;
  localparam logic [15:0] HDR = 16'hEB90;
  localparam logic [15:0] TRL = 16'h5A5A;

  logic        clk;
  logic        reset_n;
  logic        in_acq_enable;
  logic [1:0]  in_chn_select;
  logic        in_adc_valid;
  logic [15:0] in_adc_data;
  logic        in_fifo_full;
  logic        out_fifo_wr_en;
  logic [15:0] out_fifo_din;
  logic        in_clr_status;
  logic        out_busy;
  logic [15:0] out_frame_count;
  logic        out_overflow;

  usb_frame_packer #(
    .SAMPLES_PER_FRAME(SPF),
    .HEADER_WORD(HDR),
    .TRAILER_WORD(TRL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_acq_enable(in_acq_enable),
    .in_chn_select(in_chn_select),
    .in_adc_valid(in_adc_valid),
    .in_adc_data(in_adc_data),
    .in_fifo_full(in_fifo_full),
    .out_fifo_wr_en(out_fifo_wr_en),
    .out_fifo_din(out_fifo_din),
    .in_clr_status(in_clr_status),
    .out_busy(out_busy),
    .out_frame_count(out_frame_count),
    .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          passed;
  logic [15:0] mon_q[$];
  logic [15:0] exp_s[$];
  logic [1:0]  exp_chn;
  logic [15:0] frames_done;
  logic        rand_full;

  // Capture every word the FIFO accepts
  always @(negedge clk) begin
    if (reset_n && out_fifo_wr_en)
      mon_q.push_back(out_fifo_din);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_full)
      in_fifo_full = ~in_fifo_full & ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_sample(input logic [15:0] d, input bit last);
    in_adc_valid = 1'b1;
    in_adc_data  = d;
    tick();
    in_adc_valid = 1'b0;
    if (last)
      in_acq_enable = 1'b0;
    repeat (11) tick();
  endtask

  task automatic start_frame(input logic [1:0] c);
    in_chn_select = c;
    exp_chn       = c;
    in_acq_enable = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!out_busy) break;
      tick();
    end
    chk("idle_reached", 32'(out_busy), 32'd0);
  endtask

  task automatic check_frame();
    logic [15:0] exp_q[$];
    logic [15:0] sum;
    logic [15:0] w;
    logic [31:0] obs;
    sum = 16'h0000;
    exp_q.push_back(HDR);
    exp_q.push_back({frames_done[7:0], 6'b000000, exp_chn});
    for (int i = 0; i < int'(SPF); i++) begin
      w = (i < exp_s.size()) ? exp_s[i] : 16'h0000;
      exp_q.push_back(w);
      sum = sum + w;
    end
`ifdef USB_FRAME_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    exp_q.push_back(TRL);
    chk("frame_len", 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hxxxx_xxxx;
      chk($sformatf("frame%0d_word%0d", frames_done, i), obs, 32'(exp_q[i]));
    end
    frames_done = frames_done + 16'd1;
    chk("frame_count", 32'(out_frame_count), 32'(frames_done));
    mon_q.delete();
    exp_s.delete();
  endtask

  // Full frame: n samples spaced 12 cycles, enable dropped right after the last strobe
  task automatic run_frame(input logic [1:0] c, input int n, input bit randomize_data);
    logic [15:0] d;
    start_frame(c);
    if (n == 0) begin
      repeat (12) tick();
      in_acq_enable = 1'b0;
    end else begin
      repeat (12) tick();
      for (int i = 0; i < n; i++) begin
        d = randomize_data ? 16'($urandom) : exp_s[i];
        if (randomize_data) exp_s.push_back(d);
        send_sample(d, i == n - 1);
      end
    end
    wait_idle();
    check_frame();
  endtask

  int sz;

  initial begin
    total = 0; passed = 0; frames_done = 16'h0000; rand_full = 1'b0;
    reset_n = 1'b0; in_acq_enable = 1'b0; in_chn_select = 2'b00;
    in_adc_valid = 1'b0; in_adc_data = 16'h0000; in_fifo_full = 1'b0;
    in_clr_status = 1'b0; exp_chn = 2'b00;
    tick(); tick();
    chk("rst_wr_en", 32'(out_fifo_wr_en), 32'd0);
    chk("rst_din", 32'(out_fifo_din), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_count", 32'(out_frame_count), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Frame 1: header appears the cycle after enable is sampled
    start_frame(2'b01);
    tick();
    chk("hdr_timing_wr", 32'(out_fifo_wr_en), 32'd1);
    chk("hdr_timing_din", 32'(out_fifo_din), 32'(HDR));
    repeat (10) tick();
    for (int i = 0; i < 4; i++) send_sample(16'(i + 1), i == 3);
    exp_s = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    wait_idle();
    check_frame();

    // Frame 2: same stimulus, seq advances
    exp_s = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_frame(2'b01, 4, 1'b0);

    // Frame 3: early stop, padded
    exp_s = '{16'h0011, 16'h0022};
    run_frame(2'b10, 2, 1'b0);
    chk("early_stop_busy", 32'(out_busy), 32'd0);

    // Randomized frames with a stalling FIFO (never full two cycles running)
    rand_full = 1'b1;
    for (int f = 0; f < 6; f++)
      run_frame(2'($urandom_range(0, 3)), int'($urandom_range(0, SPF)), 1'b1);
    rand_full = 1'b0;
    in_fifo_full = 1'b0;
    chk("rand_no_ovf", 32'(out_overflow), 32'd0);

    // FIFO full during DATA: first sample held, second dropped
    start_frame(2'b11);
    repeat (12) tick();
    in_fifo_full = 1'b1;
    sz = mon_q.size();
    send_sample(16'hA0A0, 1'b0);
    send_sample(16'hB0B0, 1'b0);
    chk("full_no_writes", 32'(mon_q.size()), 32'(sz));
    chk("full_ovf_set", 32'(out_overflow), 32'd1);
    in_fifo_full = 1'b0;
    send_sample(16'hC0C0, 1'b0);
    send_sample(16'hD0D0, 1'b0);
    send_sample(16'hE0E0, 1'b1);
    exp_s = '{16'hA0A0, 16'hC0C0, 16'hD0D0, 16'hE0E0};
    wait_idle();
    check_frame();

    // Clear without a drop
    in_clr_status = 1'b1;
    tick();
    in_clr_status = 1'b0;
    chk("clr_only", 32'(out_overflow), 32'd0);

    // Clear coincident with a drop: set wins
    start_frame(2'b00);
    in_fifo_full = 1'b1;
    tick();
    in_adc_valid = 1'b1; in_adc_data = 16'h1234;
    tick();
    in_adc_data = 16'h5678; in_clr_status = 1'b1;
    tick();
    in_adc_valid = 1'b0; in_clr_status = 1'b0;
    chk("clr_with_drop", 32'(out_overflow), 32'd1);
    in_clr_status = 1'b1;
    tick();
    in_clr_status = 1'b0;
    chk("clr_after_drop", 32'(out_overflow), 32'd0);
    in_acq_enable = 1'b0;
    in_fifo_full = 1'b0;
    exp_s = '{16'h1234};
    wait_idle();
    check_frame();

    // Reset in the middle of DATA
    start_frame(2'b10);
    repeat (12) tick();
    send_sample(16'h7777, 1'b0);
    reset_n = 1'b0; in_acq_enable = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_busy", 32'(out_busy), 32'd0);
    chk("mid_rst_wr_en", 32'(out_fifo_wr_en), 32'd0);
    chk("mid_rst_din", 32'(out_fifo_din), 32'd0);
    chk("mid_rst_count", 32'(out_frame_count), 32'd0);
    chk("mid_rst_ovf", 32'(out_overflow), 32'd0);
    mon_q.delete();
    exp_s.delete();
    frames_done = 16'h0000;
    exp_s = '{16'h0BAD, 16'hF00D};
    run_frame(2'b10, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
